// File: rtl/message_streamer.sv
// message_streamer: sends one of four fixed ROM messages byte-by-byte to a UART transmitter
module message_streamer #(
  parameter int NUM_MSGS = 4,
  parameter bit LOOP = 1'b0,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] msg_sel,
  input  logic             abort,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  localparam logic [0:13][7:0] M0 = "Hello World!\n\r";
  localparam logic [0:13][7:0] M1 = "OK\n\r          ";
  localparam logic [0:13][7:0] M2 = "ERR\n\r         ";
  localparam logic [0:13][7:0] M3 = "Roboy\n\r       ";
  state_t state;
  logic [SEL_W-1:0] sel;
  logic [3:0] idx;
  logic [7:0] rom_q;
  logic [7:0] last_q;
  logic [1:0] m;
  logic [0:13][7:0] row;
  logic [3:0] len;
  logic last;
  logic issue;
  assign m = 2'(sel);
  assign row = m == 2'd0 ? M0 : m == 2'd1 ? M1 : m == 2'd2 ? M2 : M3;
  assign len = m == 2'd0 ? 4'd14 : m == 2'd1 ? 4'd4 : m == 2'd2 ? 4'd5 : 4'd7;
  assign last = idx == len - 4'd1;
  // abort outranks the byte strobe; the strobe is a same-cycle decode of SEND
  assign issue = state == SEND && !tx_busy && !abort;
  assign new_tx_data = issue;
  assign tx_data = issue ? rom_q : last_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // registered ROM read plus message sequencing FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      idx <= 4'd0;
      rom_q <= 8'h00;
      last_q <= 8'h00;
    end else begin
      rom_q <= idx > 4'd13 ? 8'h20 : row[idx];
      case (state)
        IDLE: if (start && 32'(msg_sel) < NUM_MSGS) begin
          sel <= msg_sel;
          idx <= 4'd0;
          state <= LOAD;
        end
        LOAD: state <= abort ? IDLE : SEND;
        SEND: if (abort) state <= IDLE;
        else if (!tx_busy) begin
          last_q <= rom_q;
          if (!last) begin
            idx <= idx + 4'd1;
            state <= LOAD;
          end else if (LOOP) begin
            idx <= 4'd0;
            state <= LOAD;
          end else state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_message_streamer.sv
// tb_message_streamer: directed checks of message_streamer in default, two-message and loop configurations
module tb_message_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic abort = 1'b0, tx_busy = 1'b0;
  logic [1:0] msg_sel = 2'd0;
  logic [7:0] tx_a, tx_b, tx_c;
  logic new_a, new_b, new_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  int n_assert = 0, n_fail = 0;
  int bc, cnt, dn;
  logic stb;
  string hello = "Hello World!\n\r";
  string m1 = "OK\n\r";
  string m2 = "ERR\n\rER";

  message_streamer u_a (.clk(clk), .rst(rst), .start(start_a), .msg_sel(msg_sel), .abort(abort),
    .tx_busy(tx_busy), .tx_data(tx_a), .new_tx_data(new_a), .busy(busy_a), .done(done_a));
  message_streamer #(.NUM_MSGS(2)) u_b (.clk(clk), .rst(rst), .start(start_b), .msg_sel(msg_sel), .abort(abort),
    .tx_busy(tx_busy), .tx_data(tx_b), .new_tx_data(new_b), .busy(busy_b), .done(done_b));
  message_streamer #(.LOOP(1'b1)) u_c (.clk(clk), .rst(rst), .start(start_c), .msg_sel(msg_sel), .abort(abort),
    .tx_busy(tx_busy), .tx_data(tx_c), .new_tx_data(new_c), .busy(busy_c), .done(done_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset state of all three instances
    next_cyc();
    next_cyc();
    #1;
    chk("rst_tx_a", tx_a, 8'h00);
    chk("rst_new_a", new_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_busy_c", busy_c, 0);
    rst = 1'b0;

    // message 1, no back-pressure: strobes at 2,4,6,8, done at 9 (abort there ignored), idle at 10
    next_cyc();
    start_a = 1'b1;
    msg_sel = 2'd1;
    #1 chk("m1_idle_busy", busy_a, 0);
    for (int k = 1; k <= 10; k++) begin
      next_cyc();
      start_a = 1'b0;
      abort = (k == 9);
      #1;
      stb = (k % 2 == 0) && (k <= 8);
      chk($sformatf("m1_stb_%0d", k), new_a, stb);
      if (stb) chk($sformatf("m1_byte_%0d", k), tx_a, m1[k/2-1]);
      if (k == 3) chk("m1_hold", tx_a, 8'h4F);
      chk($sformatf("m1_done_%0d", k), done_a, k == 9);
      chk($sformatf("m1_busy_%0d", k), busy_a, k <= 9);
    end
    abort = 1'b0;

    // message 0 with tx_busy high for 5 cycles after each byte
    next_cyc();
    start_a = 1'b1;
    msg_sel = 2'd0;
    bc = 0;
    cnt = 0;
    dn = 0;
    for (int k = 0; k < 300 && dn == 0; k++) begin
      next_cyc();
      start_a = 1'b0;
      tx_busy = (bc != 0);
      #1;
      if (new_a) begin
        chk("m0bp_strobe_while_busy", tx_busy, 0);
        chk("m0bp_in_range", cnt < 14, 1);
        if (cnt < 14) chk($sformatf("m0bp_byte_%0d", cnt), tx_a, hello[cnt]);
        cnt++;
        bc = 5;
      end else if (bc != 0) bc--;
      if (done_a) dn++;
    end
    tx_busy = 1'b0;
    chk("m0bp_count", cnt, 14);
    chk("m0bp_done", dn, 1);
    next_cyc();
    #1;
    chk("m0bp_done_once", done_a, 0);
    chk("m0bp_idle", busy_a, 0);

    // two-message instance: index 3 ignored, index 1 accepted
    next_cyc();
    start_b = 1'b1;
    msg_sel = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      start_b = 1'b0;
      #1;
      chk($sformatf("n2_busy_%0d", k), busy_b, 0);
      chk($sformatf("n2_stb_%0d", k), new_b, 0);
      chk($sformatf("n2_done_%0d", k), done_b, 0);
    end
    next_cyc();
    start_b = 1'b1;
    msg_sel = 2'd1;
    for (int k = 1; k <= 10; k++) begin
      next_cyc();
      start_b = 1'b0;
      #1;
      if (k == 1) chk("n2_accept", busy_b, 1);
      if (k == 2) chk("n2_first", tx_b, 8'h4F);
      chk($sformatf("n2_ok_done_%0d", k), done_b, k == 9);
    end

    // loop instance: message 2 repeats, abort after 7th strobe
    next_cyc();
    start_c = 1'b1;
    msg_sel = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      next_cyc();
      start_c = 1'b0;
      abort = (k == 15);
      #1;
      stb = (k % 2 == 0) && (k <= 14);
      chk($sformatf("loop_stb_%0d", k), new_c, stb);
      if (stb) chk($sformatf("loop_byte_%0d", k), tx_c, m2[k/2-1]);
      chk($sformatf("loop_done_%0d", k), done_c, 0);
      if (k == 16) chk("loop_idle", busy_c, 0);
    end
    abort = 1'b0;

    // reset during third byte of message 0, then full resend
    next_cyc();
    start_a = 1'b1;
    msg_sel = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      next_cyc();
      start_a = 1'b0;
      rst = (k == 6);
      #1;
      if (k == 6) chk("mrst_third", tx_a, hello[2]);
      if (k == 7) begin
        chk("mrst_tx", tx_a, 8'h00);
        chk("mrst_new", new_a, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
      end
    end
    next_cyc();
    start_a = 1'b1;
    msg_sel = 2'd0;
    for (int k = 1; k <= 30; k++) begin
      next_cyc();
      start_a = 1'b0;
      #1;
      stb = (k % 2 == 0) && (k <= 28);
      chk($sformatf("m0_stb_%0d", k), new_a, stb);
      if (stb) chk($sformatf("m0_byte_%0d", k), tx_a, hello[k/2-1]);
      chk($sformatf("m0_done_%0d", k), done_a, k == 29);
      if (k == 30) chk("m0_idle", busy_a, 0);
    end

    // extra starts while busy ignored; abort in SEND with tx_busy low suppresses the strobe
    next_cyc();
    start_a = 1'b1;
    msg_sel = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      next_cyc();
      start_a = (k == 1) || (k == 4);
      msg_sel = 2'd1;
      abort = (k == 8);
      #1;
      stb = (k % 2 == 0) && (k <= 6);
      chk($sformatf("ab_stb_%0d", k), new_a, stb);
      if (stb) chk($sformatf("ab_byte_%0d", k), tx_a, hello[k/2-1]);
      chk($sformatf("ab_done_%0d", k), done_a, 0);
      if (k >= 9) chk($sformatf("ab_idle_%0d", k), busy_a, 0);
    end
    start_a = 1'b0;
    abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/message_streamer.md
MESSAGE_STREAMER -- requirements
Module: message_streamer

Interface
REQ-001 Parameter NUM_MSGS, default 4, number of messages held; legal 1..4.
REQ-002 Parameter LOOP, default 0; 1 = repeat the selected message until abort.
REQ-003 Parameter SEL_W, default 2, width of msg_sel; SHALL be at least clog2(max(NUM_MSGS,2)).
REQ-004 clk  in  1  rising-edge clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to send message msg_sel.
REQ-007 msg_sel  in  SEL_W  message index, sampled only in the cycle start is accepted.
REQ-008 abort  in  1  terminate the current message.
REQ-009 tx_busy  in  1  UART transmitter busy; no byte may be issued while high.
REQ-010 tx_data  out  8  byte to transmit.
REQ-011 new_tx_data  out  1  one-cycle strobe qualifying tx_data.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse after the last byte of a message (non-loop mode only).

Function
REQ-014 The internal ROM SHALL hold these fixed messages:
- 0 = "Hello World!\n\r" (14 bytes)
- 1 = "OK\n\r" (4 bytes)
- 2 = "ERR\n\r" (5 bytes)
- 3 = "Roboy\n\r" (7 bytes)
REQ-015 Only messages with index below NUM_MSGS SHALL be reachable.
REQ-016 The ROM read SHALL be registered: 1 cycle from address to data.
REQ-017 A ROM index at or beyond a message's length SHALL return 0x20.
REQ-018 FSM states: IDLE, LOAD, SEND, DONE.
REQ-019 IDLE: start=1 with msg_sel<NUM_MSGS -> latch msg_sel, set byte index 0, go to LOAD.
REQ-020 IDLE: start=1 with msg_sel>=NUM_MSGS -> ignored, stay in IDLE, no outputs.
REQ-021 start in any state other than IDLE SHALL be ignored.
REQ-022 LOAD SHALL last exactly 1 cycle while the ROM data settles, then go to SEND.
REQ-023 SEND with tx_busy=1: hold state, keep new_tx_data=0.
REQ-024 SEND with tx_busy=0, when not on the last byte: new_tx_data=1 and tx_data=ROM byte in the same cycle; increment index; go to LOAD.
REQ-025 SEND with tx_busy=0 on the last byte (index = length-1):
- LOOP=0: issue the byte, go to DONE.
- LOOP=1: issue the byte, reset index to 0, go to LOAD.
REQ-026 DONE: done=1 for exactly 1 cycle, then go to IDLE.
REQ-027 Maximum rate SHALL be 1 byte per 2 cycles; an N-byte message with tx_busy held low SHALL take 2N+1 cycles from start to done.
REQ-028 The index counter SHALL be 4 bits, wrap only via REQ-025, and never exceed 13.
REQ-029 abort=1 in LOAD or SEND SHALL win over a same-cycle byte issue: no strobe, no done, go to IDLE next cycle.
REQ-030 abort in IDLE or DONE SHALL be ignored; a pending done still pulses.
REQ-031 tx_data SHALL hold its last value when new_tx_data=0.

Reset
REQ-032 While rst=1 on a clock edge: state=IDLE, index=0, tx_data=0x00, new_tx_data=0, busy=0, done=0.
REQ-033 rst mid-message SHALL abandon the message: no further strobes, no done.
REQ-034 Reset has priority over start and abort.

Verification
REQ-035 LOOP=0, tx_busy=0, start with msg_sel=1 -> strobes on cycles 2,4,6,8 after start carrying 0x4F,0x4B,0x0A,0x0D; done on cycle 9; busy low on cycle 10.
REQ-036 msg_sel=0, tx_busy held high 5 cycles at each byte -> 14 strobes in order "Hello World!\n\r", never while tx_busy=1, exactly one done.
REQ-037 NUM_MSGS=2, start with msg_sel=3 -> busy stays 0, no strobe, no done.
REQ-038 LOOP=1, msg_sel=2, abort after the 7th strobe -> bytes "ERR\n\rER" then idle, no done, busy=0 within 1 cycle.
REQ-039 rst asserted during byte 3 of message 0 -> all outputs zero next cycle; a new start then sends the full message from 'H'.
REQ-040 start pulsed again while busy, and abort coincident with tx_busy=0 in SEND -> both starts beyond the first ignored; no strobe in the abort cycle.
